fe_op_credit_arbiter: RTL and testbench

// - Shares one pipelined single-beat Fp/Fp2 op unit (adder_pipe, subtractor_pipe, ec_fp_mult_mod) among NUM_IN requesters.
// - Arbitration is round-robin; each requester has an outstanding-op credit limit.
// - Sits between ec_fe2/fe6 arithmetic blocks and the shared unit.
// - The credit limit stops one requester filling the pipe and head-of-line blocking the others.

---
 rtl/fe_op_credit_arbiter_pkg.sv | 27 ++
 rtl/fe_op_credit_arbiter_credit_counter.sv | 34 +++
 rtl/fe_op_credit_arbiter.sv | 167 ++++++++++++++++
 tb/tb_fe_op_credit_arbiter.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fe_op_credit_arbiter_pkg.sv
// Shared types and the round-robin pick helper for the op-unit credit arbiter.
package fe_op_credit_arbiter_pkg;

  localparam int RR_MAX = 16;

  typedef struct packed {
    logic       vld;
    logic [3:0] idx;
  } rr_pick_t;

  // First set bit of req scanning ptr, ptr+1, ... (mod 16). Requests above
  // NUM_IN are tied low, so the mod-16 scan equals a mod-NUM_IN scan.
  function automatic rr_pick_t rr_pick(input logic [15:0] req, input logic [3:0] ptr);
    rr_pick_t   pick;
    logic [3:0] k;
    pick = '0;
    for (int i = RR_MAX - 1; i >= 0; i--) begin
      k = ptr + 4'(i);
      if (req[k]) begin
        pick.vld = 1'b1;
        pick.idx = k;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/fe_op_credit_arbiter_credit_counter.sv
// Per-requester outstanding-op counter: saturating up/down with max/zero flags.
module fe_op_credit_arbiter_credit_counter #(
  parameter int MAX_OUT = 8,
  parameter int CNT_W   = $clog2(MAX_OUT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             at_max,
  output logic             is_zero
);

  localparam logic [CNT_W-1:0] MAX_VAL = CNT_W'(MAX_OUT);

  logic [CNT_W-1:0] cnt_reg;

  assign cnt     = cnt_reg;
  assign at_max  = (cnt_reg == MAX_VAL);
  assign is_zero = (cnt_reg == '0);

  // Simultaneous inc and dec cancel out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (inc && !dec && !at_max) begin
      cnt_reg <= cnt_reg + 1'b1;
    end else if (dec && !inc && !is_zero) begin
      cnt_reg <= cnt_reg - 1'b1;
    end
  end

endmodule

// File: rtl/fe_op_credit_arbiter.sv
// Round-robin arbiter sharing one pipelined Fp/Fp2 op unit among NUM_IN
// requesters, with a per-requester in-flight credit limit and response demux.
module fe_op_credit_arbiter
  import fe_op_credit_arbiter_pkg::*;
#(
  parameter int NUM_IN      = 4,
  parameter int DAT_BITS    = 762,
  parameter int RES_BITS    = 381,
  parameter int CTL_BITS    = 24,
  parameter int OVR_WRT_BIT = 16,
  parameter int MAX_OUT     = 8,
  localparam int IDX_W      = $clog2(NUM_IN),
  localparam int CNT_W      = $clog2(MAX_OUT + 1),
  localparam int MOD_BITS   = $clog2(DAT_BITS / 8)
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [NUM_IN-1:0]            i_axi_val,
  output logic [NUM_IN-1:0]            i_axi_rdy,
  input  logic [NUM_IN*DAT_BITS-1:0]   i_axi_dat,
  input  logic [NUM_IN*CTL_BITS-1:0]   i_axi_ctl,
  output logic                         o_res_val,
  input  logic                         o_res_rdy,
  output logic [DAT_BITS-1:0]          o_res_dat,
  output logic [CTL_BITS-1:0]          o_res_ctl,
  output logic                         o_res_sop,
  output logic                         o_res_eop,
  output logic                         o_res_err,
  output logic [MOD_BITS-1:0]          o_res_mod,
  input  logic                         i_res_val,
  output logic                         i_res_rdy,
  input  logic [RES_BITS-1:0]          i_res_dat,
  input  logic [CTL_BITS-1:0]          i_res_ctl,
  output logic [NUM_IN-1:0]            o_axi_val,
  input  logic [NUM_IN-1:0]            o_axi_rdy,
  output logic [NUM_IN*RES_BITS-1:0]   o_axi_dat,
  output logic [NUM_IN*CTL_BITS-1:0]   o_axi_ctl,
  output logic                         o_err
);

  localparam logic [IDX_W:0] NUM_IN_W = (IDX_W + 1)'(NUM_IN);

  logic [NUM_IN-1:0]   elig;
  logic [NUM_IN-1:0]   at_max;
  logic [NUM_IN-1:0]   is_zero;
  logic [NUM_IN-1:0]   inc;
  logic [NUM_IN-1:0]   dec;
  logic [15:0]         elig_req;
  logic [3:0]          ptr_ext;
  rr_pick_t            pick;
  logic                can_load;
  logic                grant_vld;
  logic [IDX_W-1:0]    rr_ptr_reg;
  logic [IDX_W-1:0]    rr_ptr_next;
  logic                o_res_val_reg;
  logic [DAT_BITS-1:0] o_res_dat_reg;
  logic [CTL_BITS-1:0] o_res_ctl_reg;
  logic [DAT_BITS-1:0] sel_dat;
  logic [CTL_BITS-1:0] sel_ctl;
  logic [IDX_W-1:0]    res_idx;
  logic                res_idx_ok;
  logic                res_zero;
  logic                res_lane_rdy;
  logic                res_bad;
  logic                o_err_reg;

  // Credit bookkeeping and response demux, one lane per requester.
  for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_lane
    assign elig[gi]      = i_axi_val[gi] & ~at_max[gi];
    assign i_axi_rdy[gi] = grant_vld & (pick.idx == 4'(gi));
    assign inc[gi]       = i_axi_rdy[gi];
    assign o_axi_val[gi] = ~i_rst & i_res_val & ~res_bad & (res_idx == IDX_W'(gi));
    assign dec[gi]       = o_axi_val[gi] & o_axi_rdy[gi];
    assign o_axi_dat[gi*RES_BITS +: RES_BITS] = i_res_dat;
    assign o_axi_ctl[gi*CTL_BITS +: CTL_BITS] = i_res_ctl;

    fe_op_credit_arbiter_credit_counter #(
      .MAX_OUT (MAX_OUT),
      .CNT_W   (CNT_W)
    ) u_credit (
      .clk     (i_clk),
      .rst     (i_rst),
      .inc     (inc[gi]),
      .dec     (dec[gi]),
      .cnt     (),
      .at_max  (at_max[gi]),
      .is_zero (is_zero[gi])
    );
  end

  // Request side: pick, select payload, stamp the requester index into ctl.
  always_comb begin
    elig_req                = '0;
    elig_req[NUM_IN-1:0]    = elig;
    ptr_ext                 = '0;
    ptr_ext[IDX_W-1:0]      = rr_ptr_reg;
    pick                    = rr_pick(elig_req, ptr_ext);
    can_load                = ~o_res_val_reg | o_res_rdy;
    grant_vld               = pick.vld & can_load & ~i_rst;
    rr_ptr_next             = (pick.idx == 4'(NUM_IN - 1)) ? '0 : IDX_W'(pick.idx + 4'd1);
    sel_dat                 = '0;
    sel_ctl                 = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (pick.idx == 4'(k)) begin
        sel_dat = i_axi_dat[k*DAT_BITS +: DAT_BITS];
        sel_ctl = i_axi_ctl[k*CTL_BITS +: CTL_BITS];
      end
    end
    sel_ctl[OVR_WRT_BIT +: IDX_W] = IDX_W'(pick.idx);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_res_val_reg <= 1'b0;
      rr_ptr_reg    <= '0;
    end else if (grant_vld) begin
      o_res_val_reg <= 1'b1;
      rr_ptr_reg    <= rr_ptr_next;
    end else if (o_res_rdy) begin
      o_res_val_reg <= 1'b0;
    end
  end

  // Payload needs no reset: it is only observed while o_res_val is high.
  always_ff @(posedge i_clk) begin
    if (grant_vld) begin
      o_res_dat_reg <= sel_dat;
      o_res_ctl_reg <= sel_ctl;
    end
  end

  assign o_res_val = o_res_val_reg;
  assign o_res_dat = o_res_dat_reg;
  assign o_res_ctl = o_res_ctl_reg;
  assign o_res_sop = 1'b1;
  assign o_res_eop = 1'b1;
  assign o_res_err = 1'b0;
  assign o_res_mod = '0;

  // Response side: a bad index or a response with no credit outstanding is
  // swallowed so the shared unit never stalls on it.
  always_comb begin
    res_idx      = i_res_ctl[OVR_WRT_BIT +: IDX_W];
    res_idx_ok   = ({1'b0, res_idx} < NUM_IN_W);
    res_zero     = 1'b0;
    res_lane_rdy = 1'b0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (res_idx == IDX_W'(k)) begin
        res_zero     = is_zero[k];
        res_lane_rdy = o_axi_rdy[k];
      end
    end
    res_bad   = ~res_idx_ok | res_zero;
    i_res_rdy = ~i_rst & (res_bad | res_lane_rdy);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_err_reg <= 1'b0;
    end else if (i_res_val && res_bad) begin
      o_err_reg <= 1'b1;
    end
  end

  assign o_err = o_err_reg;

endmodule

// File: tb/tb_fe_op_credit_arbiter.sv
// Directed bench for fe_op_credit_arbiter with a latency-10 stand-in op unit.
module tb_fe_op_credit_arbiter;

  localparam int NUM_IN   = 4;
  localparam int DAT_BITS = 762;
  localparam int RES_BITS = 381;
  localparam int CTL_BITS = 24;
  localparam int OVR      = 16;
  localparam int MAX_OUT  = 2;
  localparam int LAT      = 10;
  localparam int MOD_BITS = $clog2(DAT_BITS / 8);
  localparam int N_RAND   = 12;

  logic                       clk = 1'b0;
  logic                       rst;
  logic [NUM_IN-1:0]          i_axi_val;
  logic [NUM_IN-1:0]          i_axi_rdy;
  logic [NUM_IN*DAT_BITS-1:0] i_axi_dat;
  logic [NUM_IN*CTL_BITS-1:0] i_axi_ctl;
  logic                       o_res_val;
  logic                       o_res_rdy;
  logic [DAT_BITS-1:0]        o_res_dat;
  logic [CTL_BITS-1:0]        o_res_ctl;
  logic                       o_res_sop;
  logic                       o_res_eop;
  logic                       o_res_err;
  logic [MOD_BITS-1:0]        o_res_mod;
  logic                       i_res_val;
  logic                       i_res_rdy;
  logic [RES_BITS-1:0]        i_res_dat;
  logic [CTL_BITS-1:0]        i_res_ctl;
  logic [NUM_IN-1:0]          o_axi_val;
  logic [NUM_IN-1:0]          o_axi_rdy;
  logic [NUM_IN*RES_BITS-1:0] o_axi_dat;
  logic [NUM_IN*CTL_BITS-1:0] o_axi_ctl;
  logic                       o_err;

  always #5 clk = ~clk;

  fe_op_credit_arbiter #(
    .NUM_IN(NUM_IN), .DAT_BITS(DAT_BITS), .RES_BITS(RES_BITS),
    .CTL_BITS(CTL_BITS), .OVR_WRT_BIT(OVR), .MAX_OUT(MAX_OUT)
  ) dut (
    .i_clk(clk), .i_rst(rst),
    .i_axi_val(i_axi_val), .i_axi_rdy(i_axi_rdy), .i_axi_dat(i_axi_dat), .i_axi_ctl(i_axi_ctl),
    .o_res_val(o_res_val), .o_res_rdy(o_res_rdy), .o_res_dat(o_res_dat), .o_res_ctl(o_res_ctl),
    .o_res_sop(o_res_sop), .o_res_eop(o_res_eop), .o_res_err(o_res_err), .o_res_mod(o_res_mod),
    .i_res_val(i_res_val), .i_res_rdy(i_res_rdy), .i_res_dat(i_res_dat), .i_res_ctl(i_res_ctl),
    .o_axi_val(o_axi_val), .o_axi_rdy(o_axi_rdy), .o_axi_dat(o_axi_dat), .o_axi_ctl(o_axi_ctl),
    .o_err(o_err)
  );

  // Stand-in arithmetic: add, sub, or a 64x64 multiply of the two halves.
  function automatic logic [RES_BITS-1:0] fp_op(input logic [1:0] op, input logic [DAT_BITS-1:0] d);
    logic [RES_BITS-1:0] a;
    logic [RES_BITS-1:0] b;
    logic [127:0]        p;
    a = d[RES_BITS-1:0];
    b = d[DAT_BITS-1:RES_BITS];
    p = {64'd0, a[63:0]} * {64'd0, b[63:0]};
    case (op)
      2'd0:    return a + b;
      2'd1:    return a - b;
      default: return RES_BITS'(p);
    endcase
  endfunction

  function automatic logic [DAT_BITS-1:0] rnd_dat();
    logic [DAT_BITS-1:0] r;
    r = '0;
    for (int i = 0; i < DAT_BITS; i += 32) r = {r[DAT_BITS-33:0], 32'($urandom)};
    return r;
  endfunction

  // ---- shared op unit model: LAT-stage delay line into a response FIFO ----
  logic                unit_en, inject, inj_val;
  logic [CTL_BITS-1:0] inj_ctl;
  logic [RES_BITS-1:0] inj_dat;
  logic                pl_val [LAT];
  logic [CTL_BITS-1:0] pl_ctl [LAT];
  logic [RES_BITS-1:0] pl_dat [LAT];
  logic [CTL_BITS-1:0] f_ctl [16];
  logic [RES_BITS-1:0] f_dat [16];
  logic [4:0]          f_wr, f_rd;
  logic                mdl_val;

  assign mdl_val = (f_wr != f_rd);

  always_comb begin
    i_res_val = inject ? inj_val : mdl_val;
    i_res_dat = inject ? inj_dat : f_dat[f_rd[3:0]];
    i_res_ctl = inject ? inj_ctl : f_ctl[f_rd[3:0]];
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) pl_val[i] <= 1'b0;
      f_wr <= '0;
      f_rd <= '0;
    end else begin
      pl_val[0] <= unit_en & o_res_val & o_res_rdy;
      pl_ctl[0] <= o_res_ctl;
      pl_dat[0] <= fp_op(o_res_ctl[1:0], o_res_dat);
      for (int i = 1; i < LAT; i++) begin
        pl_val[i] <= pl_val[i-1];
        pl_ctl[i] <= pl_ctl[i-1];
        pl_dat[i] <= pl_dat[i-1];
      end
      if (pl_val[LAT-1]) begin
        f_ctl[f_wr[3:0]] <= pl_ctl[LAT-1];
        f_dat[f_wr[3:0]] <= pl_dat[LAT-1];
        f_wr <= f_wr + 5'd1;
      end
      if (!inject && mdl_val && i_res_rdy) f_rd <= f_rd + 5'd1;
    end
  end

  // ---- checking ----
  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [767:0] got, input logic [767:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int oh2idx(input logic [NUM_IN-1:0] v);
    for (int i = 0; i < NUM_IN; i++) if (v[i]) return i;
    return -1;
  endfunction

  int                  n_gnt, n_rsp, g;
  logic [DAT_BITS-1:0] d0;
  logic [RES_BITS-1:0] e, got;
  logic [RES_BITS-1:0] q0 [$];
  logic [RES_BITS-1:0] q1 [$];
  int                  iss [2];
  int                  rcv [2];
  logic                nxt [2];
  logic [CTL_BITS-1:0] ctl_t;

  initial begin
    rst = 1'b1;
    i_axi_val = '0; i_axi_ctl = '0; o_res_rdy = 1'b1; o_axi_rdy = '1;
    unit_en = 1'b1; inject = 1'b0; inj_val = 1'b0; inj_ctl = '0; inj_dat = '0;
    for (int k = 0; k < NUM_IN; k++) i_axi_dat[k*DAT_BITS +: DAT_BITS] = rnd_dat();
    repeat (3) tick();

    // Reset state; requests must not be accepted while in reset.
    i_axi_val = 4'hF;
    #1;
    check("rst_o_res_val", o_res_val, 0);
    check("rst_i_axi_rdy", i_axi_rdy, 0);
    check("rst_o_axi_val", o_axi_val, 0);
    check("rst_i_res_rdy", i_res_rdy, 0);
    check("rst_o_err", o_err, 0);

    // All four requesters busy: 0,1,2,3,0,1,2,3, then stall until a response.
    rst = 1'b0;
    #1;
    n_gnt = 0; n_rsp = 0;
    for (int c = 0; c < 60 && n_gnt < 9; c++) begin
      if (|i_axi_rdy) begin
        g = oh2idx(i_axi_rdy);
        if (n_gnt < 8) check("rr_order", g, n_gnt % 4);
        else begin
          check("rr_stall_until_resp", (n_rsp > 0), 1);
          check("rr_first_after_resp", g, 0);
        end
        n_gnt++;
      end
      if (|(o_axi_val & o_axi_rdy)) n_rsp++;
      tick();
    end
    check("rr_grant_count", n_gnt, 9);
    i_axi_val = '0;
    repeat (40) tick();

    // Single requester with responses held: credit limit of 2.
    o_axi_rdy = '0;
    i_axi_val = 4'b0100;
    #1;
    n_gnt = 0;
    for (int c = 0; c < 20; c++) begin
      if (i_axi_rdy[2]) n_gnt++;
      tick();
    end
    check("credit_issued", n_gnt, 2);
    check("credit_rdy_low", i_axi_rdy, 0);
    check("credit_resp_waiting", o_axi_val, 4'b0100);
    o_axi_rdy = 4'b0100;
    #1;
    check("credit_i_res_rdy", i_res_rdy, 1);
    tick();
    o_axi_rdy = '0;
    #1;
    n_gnt = 0;
    for (int c = 0; c < 8; c++) begin
      if (i_axi_rdy[2]) n_gnt++;
      tick();
    end
    check("credit_one_more", n_gnt, 1);
    i_axi_val = '0;
    o_axi_rdy = '1;
    repeat (40) tick();

    // ctl rewrite on request, routing of a returned ctl on response.
    unit_en = 1'b0;
    i_axi_ctl[3*CTL_BITS +: CTL_BITS] = 24'h00ABCD;
    i_axi_val = 4'b1000;
    #1;
    check("ctl_grant3", i_axi_rdy, 4'b1000);
    d0 = i_axi_dat[3*DAT_BITS +: DAT_BITS];
    tick();
    i_axi_val = '0;
    #1;
    check("ctl_o_res_val", o_res_val, 1);
    check("ctl_rewrite", o_res_ctl, 24'h03ABCD);
    check("ctl_dat", o_res_dat, d0);
    tick();
    inject = 1'b1; inj_ctl = 24'h031234; inj_dat = RES_BITS'(rnd_dat()); inj_val = 1'b1;
    #1;
    check("resp_route_val", o_axi_val, 4'b1000);
    check("resp_route_ctl", o_axi_ctl[3*CTL_BITS +: CTL_BITS], 24'h031234);
    check("resp_route_dat", o_axi_dat[3*RES_BITS +: RES_BITS], inj_dat);
    check("resp_route_rdy", i_res_rdy, 1);
    tick();
    inj_val = 1'b0;
    #1;
    check("resp_no_err", o_err, 0);
    inject = 1'b0;
    unit_en = 1'b1;
    i_axi_ctl = '0;

    // Output stall: o_res held stable, no grants, then resume round-robin.
    i_axi_ctl[0*CTL_BITS +: CTL_BITS] = 24'h005A5A;
    i_axi_ctl[1*CTL_BITS +: CTL_BITS] = 24'h000F0F;
    o_res_rdy = 1'b0;
    i_axi_val = 4'b0011;
    #1;
    check("stall_first_grant", i_axi_rdy, 4'b0001);
    d0 = i_axi_dat[0 +: DAT_BITS];
    tick();
    i_axi_dat[0 +: DAT_BITS] = rnd_dat();
    #1;
    for (int c = 0; c < 5; c++) begin
      check("stall_val", o_res_val, 1);
      check("stall_ctl", o_res_ctl, 24'h005A5A);
      check("stall_dat", o_res_dat, d0);
      check("stall_no_rdy", i_axi_rdy, 0);
      tick();
    end
    o_res_rdy = 1'b1;
    #1;
    check("stall_resume_rr", i_axi_rdy, 4'b0010);
    tick();
    i_axi_val = '0;
    #1;
    check("stall_resume_ctl", o_res_ctl, 24'h010F0F);
    i_axi_ctl = '0;
    repeat (40) tick();

    // Response to a requester with no credit: dropped, sticky error.
    inject = 1'b1; inj_ctl = 24'h010000; inj_val = 1'b1;
    #1;
    check("err_lane_val", o_axi_val, 0);
    check("err_i_res_rdy", i_res_rdy, 1);
    tick();
    inj_val = 1'b0;
    #1;
    check("err_set", o_err, 1);
    repeat (3) tick();
    check("err_sticky", o_err, 1);
    inject = 1'b0;

    // Reset with ops in flight: everything drops, pointer and credits clear.
    o_axi_rdy = '0;
    i_axi_val = 4'b0111;
    #1;
    repeat (3) tick();
    #3;
    rst = 1'b1;
    #1;
    check("midrst_o_res_val", o_res_val, 0);
    check("midrst_i_axi_rdy", i_axi_rdy, 0);
    check("midrst_o_axi_val", o_axi_val, 0);
    check("midrst_i_res_rdy", i_res_rdy, 0);
    check("midrst_o_err", o_err, 0);
    repeat (2) tick();
    rst = 1'b0;
    #1;
    check("midrst_first_grant", i_axi_rdy, 4'b0001);
    i_axi_val = 4'b0001;
    #1;
    n_gnt = 0;
    for (int c = 0; c < 20; c++) begin
      if (i_axi_rdy[0]) n_gnt++;
      tick();
    end
    check("midrst_credit_cleared", n_gnt, 2);
    i_axi_val = '0;
    o_axi_rdy = '1;
    repeat (40) tick();

    // Random mixed ops from two requesters with random back-pressure.
    for (int k = 0; k < 2; k++) begin
      iss[k] = 0; rcv[k] = 0; nxt[k] = 1'b1;
    end
    for (int c = 0; c < 3000 && (rcv[0] < N_RAND || rcv[1] < N_RAND); c++) begin
      for (int k = 0; k < 2; k++) begin
        if (nxt[k]) begin
          i_axi_dat[k*DAT_BITS +: DAT_BITS] = rnd_dat();
          ctl_t = 24'($urandom);
          ctl_t[1:0] = 2'($urandom_range(0, 2));
          i_axi_ctl[k*CTL_BITS +: CTL_BITS] = ctl_t;
          nxt[k] = 1'b0;
        end
        i_axi_val[k] = (iss[k] < N_RAND);
      end
      o_res_rdy = ($urandom_range(0, 3) != 0);
      o_axi_rdy = 4'($urandom);
      #1;
      for (int k = 0; k < 2; k++) begin
        if (i_axi_val[k] && i_axi_rdy[k]) begin
          e = fp_op(i_axi_ctl[k*CTL_BITS +: 2], i_axi_dat[k*DAT_BITS +: DAT_BITS]);
          if (k == 0) q0.push_back(e);
          else q1.push_back(e);
          iss[k]++;
          nxt[k] = 1'b1;
        end
        if (o_axi_val[k] && o_axi_rdy[k]) begin
          got = o_axi_dat[k*RES_BITS +: RES_BITS];
          if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0))
            check("rand_unexpected_resp", k, -1);
          else begin
            e = (k == 0) ? q0.pop_front() : q1.pop_front();
            check("rand_result", got, e);
          end
          rcv[k]++;
        end
      end
      if (|o_axi_val[3:2]) check("rand_stray_lane", o_axi_val[3:2], 0);
      tick();
    end
    check("rand_recv0", rcv[0], N_RAND);
    check("rand_recv1", rcv[1], N_RAND);
    check("rand_no_err", o_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
